// File: rtl/sort_insert_ctrl.sv
// Insert sequencer for the systolic sort-cell array: PLACE -> WRITE -> ORDER per record, plus occupancy and clear.
// Optional SORT_CTRL_STATS_EN macro enables the insert_total / drop_total counters.
module sort_insert_ctrl #(
    parameter int SORT_WIDTH = 32,
    parameter int NUM_CELLS  = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SORT_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  clear,
    output logic [SORT_WIDTH-1:0] datain,
    output logic                  place_en,
    output logic                  wren,
    output logic                  order,
    output logic                  array_reset,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  busy,
    output logic                  insert_done,
    output logic [31:0]           insert_total,
    output logic [31:0]           drop_total,
    output logic [2:0]            fsm_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLACE = 3'd1,
        WRITE = 3'd2,
        ORDER = 3'd3,
        CLR   = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(NUM_CELLS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                state;
    state_t                state_next;
    logic [SORT_WIDTH-1:0] hold;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  accept;

    // Handshake: a record transfers on a cycle where in_valid && in_ready.
    // in_ready is offered in IDLE and in ORDER (so the next insert overlaps
    // the ORDER cycle), never while reset or clear is asserted.
    always_comb begin
        in_ready = 1'b0;
        accept   = 1'b0;
        if (!reset && !clear && (state == IDLE || state == ORDER)) begin
            in_ready = 1'b1;
        end
        accept = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        place_en    = 1'b0;
        wren        = 1'b0;
        order       = 1'b0;
        insert_done = 1'b0;
        array_reset = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = PLACE;
                end
            end
            PLACE: begin
                place_en   = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                wren       = 1'b1;
                state_next = ORDER;
            end
            ORDER: begin
                order       = 1'b1;
                insert_done = 1'b1;
                state_next  = accept ? PLACE : IDLE;
            end
            CLR: begin
                array_reset = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Clear aborts whatever is in flight; no further strobes for it.
        if (clear) begin
            state_next = CLR;
        end
    end

    // The hold register is the broadcast bus itself, stable PLACE..ORDER.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else if (accept) begin
            hold <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (state == CLR) begin
            count_q <= '0;
        end else if (state == ORDER && count_q != CNT_MAX) begin
            count_q <= count_q + CNT_ONE;
        end
    end

    assign datain    = hold;
    assign count     = count_q;
    assign full      = (count_q == CNT_MAX);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

`ifdef SORT_CTRL_STATS_EN
    logic [31:0] insert_total_q;
    logic [31:0] drop_total_q;

    // A drop is an insert that lands while the array is already full.
    always_ff @(posedge clk) begin
        if (reset) begin
            insert_total_q <= '0;
            drop_total_q   <= '0;
        end else if (state == ORDER) begin
            insert_total_q <= insert_total_q + 32'd1;
            if (full) begin
                drop_total_q <= drop_total_q + 32'd1;
            end
        end
    end

    assign insert_total = insert_total_q;
    assign drop_total   = drop_total_q;
`else
    assign insert_total = 32'd0;
    assign drop_total   = 32'd0;
`endif

endmodule

// File: tb/tb_sort_insert_ctrl.sv
// Self-checking bench for sort_insert_ctrl (NUM_CELLS=6): vector table for occupancy, hand sequences for corners.
module tb_sort_insert_ctrl;

  localparam int SW = 32;
  localparam int NC = 6;
  localparam int CW = 3;
`ifdef SORT_CTRL_STATS_EN
  localparam logic STATS = 1'b1;
`else
  localparam logic STATS = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [SW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          clear;
  logic [SW-1:0] datain;
  logic          place_en;
  logic          wren;
  logic          order;
  logic          array_reset;
  logic [CW-1:0] count;
  logic          full;
  logic          busy;
  logic          insert_done;
  logic [31:0]   insert_total;
  logic [31:0]   drop_total;
  logic [2:0]    fsm_state;

  int total = 0;
  int bad = 0;
  logic [SW-1:0] exp_q[$];

  typedef struct {
    logic [SW-1:0] data;
    logic [CW-1:0] exp_count;
    logic          exp_full;
  } vec_t;
  vec_t vecs[8];

  sort_insert_ctrl #(.SORT_WIDTH(SW), .NUM_CELLS(NC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .datain(datain), .place_en(place_en),
    .wren(wren), .order(order), .array_reset(array_reset), .count(count),
    .full(full), .busy(busy), .insert_done(insert_done),
    .insert_total(insert_total), .drop_total(drop_total), .fsm_state(fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] st(input logic [31:0] v);
    return STATS ? v : 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [SW-1:0] d);
    in_data = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    check("clr_pulse", {31'd0, array_reset}, 32'd1);
    clear = 1'b0;
    @(negedge clk);
    check("clr_count", {29'd0, count}, 32'd0);
    check("clr_pulse_end", {31'd0, array_reset}, 32'd0);
  endtask

  // scoreboard: sampled 1 time unit after the negedge so driver updates have settled
  always @(negedge clk) begin
    #1;
    check("strobe_onehot", ($countones({place_en, wren, order}) > 1) ? 32'd1 : 32'd0, 32'd0);
    check("done_eq_order", {31'd0, insert_done}, {31'd0, order});
    if (order) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_order", 32'd1, 32'd0);
      end else begin
        check("sb_datain", datain, exp_q.pop_front());
      end
    end
    if (reset || array_reset) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(in_data);
  end

  initial begin
    int acc[5];
    int n;
    int cyc;
    logic [SW-1:0] y;

    reset = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vecs[i].data = $urandom;
      vecs[i].exp_count = (i < NC) ? CW'(i + 1) : CW'(NC);
      vecs[i].exp_full = (i >= NC - 1);
    end

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_datain", datain, 32'd0);
    check("rst_strobes", {27'd0, place_en, wren, order, array_reset, insert_done}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_full_busy", {30'd0, full, busy}, 32'd0);
    check("rst_stats", insert_total | drop_total, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // single insert: accept at T
    in_data = 32'h3F80_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("t1_place", {29'd0, place_en, wren, order}, 32'b100);
    check("t1_datain", datain, 32'h3F80_0000);
    check("t1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t2_wren", {29'd0, place_en, wren, order}, 32'b010);
    check("t2_datain", datain, 32'h3F80_0000);
    @(negedge clk);
    check("t3_order", {29'd0, place_en, wren, order}, 32'b001);
    check("t3_done", {31'd0, insert_done}, 32'd1);
    check("t3_datain", datain, 32'h3F80_0000);
    check("t3_count", {29'd0, count}, 32'd0);
    @(negedge clk);
    check("t4_count", {29'd0, count}, 32'd1);
    check("t4_idle", {30'd0, busy, order}, 32'd0);
    check("t4_ins_total", insert_total, st(32'd1));

    // back-to-back: in_valid held for 5 records
    do_clear();
    n = 0;
    cyc = 0;
    in_data = $urandom;
    in_valid = 1'b1;
    while (n < 5 && cyc < 40) begin
      check("b2b_ready_phase", {31'd0, in_ready}, {31'd0, order || !busy});
      if (in_ready) begin
        acc[n] = cyc;
        n++;
      end
      @(negedge clk);
      cyc++;
      if (n < 5) in_data = $urandom;
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("b2b_accepts", n, 32'd5);
    for (int i = 1; i < 5; i++) check("b2b_spacing", acc[i] - acc[i-1], 32'd3);
    wait_idle();
    check("b2b_count", {29'd0, count}, 32'd5);
    check("b2b_ins_total", insert_total, st(32'd6));

    // table-driven occupancy / saturation
    do_clear();
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].data);
      wait_idle();
      check("tbl_count", {29'd0, count}, {29'd0, vecs[i].exp_count});
      check("tbl_full", {31'd0, full}, {31'd0, vecs[i].exp_full});
    end
    check("tbl_ins_total", insert_total, st(32'd14));
    check("tbl_drop_total", drop_total, st(32'd2));

    // clear in the WRITE cycle
    send(32'hDEAD_BEEF);
    check("cw_place", {31'd0, place_en}, 32'd1);
    @(negedge clk);
    check("cw_wren", {31'd0, wren}, 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("cw_no_order", {30'd0, order, insert_done}, 32'd0);
    check("cw_array_reset", {31'd0, array_reset}, 32'd1);
    @(negedge clk);
    check("cw_ar_one_cycle", {31'd0, array_reset}, 32'd0);
    check("cw_no_order2", {30'd0, order, insert_done}, 32'd0);
    check("cw_count", {29'd0, count}, 32'd0);
    check("cw_idle_ready", {30'd0, busy, in_ready}, 32'b01);
    check("cw_ins_total", insert_total, st(32'd14));

    // clear and accept in the same IDLE cycle, clear held 2 cycles
    y = $urandom;
    in_data = y;
    in_valid = 1'b1;
    clear = 1'b1;
    #1;
    check("ca_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("ca_clr1", {30'd0, array_reset, place_en}, 32'b10);
    @(negedge clk);
    check("ca_clr2", {30'd0, array_reset, place_en}, 32'b10);
    clear = 1'b0;
    @(negedge clk);
    check("ca_idle", {30'd0, in_ready, place_en}, 32'b10);
    @(negedge clk);
    in_valid = 1'b0;
    check("ca_place", {31'd0, place_en}, 32'd1);
    check("ca_datain", datain, y);
    wait_idle();
    check("ca_count", {29'd0, count}, 32'd1);
    check("ca_ins_total", insert_total, st(32'd15));

    // reset during ORDER
    do_clear();
    send(32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    check("ro_order", {31'd0, order}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("ro_strobes", {27'd0, place_en, wren, order, array_reset, insert_done}, 32'd0);
    check("ro_count", {29'd0, count}, 32'd0);
    check("ro_flags", {29'd0, full, busy, in_ready}, 32'd0);
    check("ro_datain", datain, 32'd0);
    check("ro_stats", insert_total | drop_total, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ro_ready", {31'd0, in_ready}, 32'd1);

    @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not end, expected finish");
    $fatal(1);
  end

endmodule
